// File: rtl/vec_mul_sched.sv
// Shares one vector-by-scalar float multiplier among NREQ requesters: round-robin issue,
// credit-limited outstanding operations, and in-order routing of results back to their owners.
module vec_mul_sched #(
    parameter int SIZE    = 32,
    parameter int NREQ    = 2,
    parameter int MAX_OUT = 16
) (
    input  logic                                 aclk,
    input  logic                                 aresetn,
    // requester side
    input  logic [NREQ-1:0][2:0][SIZE-1:0]       s_req_a_tdata,
    input  logic [NREQ-1:0][SIZE-1:0]            s_req_b_tdata,
    input  logic [NREQ-1:0]                      s_req_tvalid,
    output logic [NREQ-1:0]                      s_req_tready,
    output logic [2:0][SIZE-1:0]                 m_rsp_tdata,
    output logic [NREQ-1:0]                      m_rsp_tvalid,
    input  logic [NREQ-1:0]                      m_rsp_tready,
    // shared multiplier side
    output logic [2:0][SIZE-1:0]                 m_mul_a_tdata,
    output logic [SIZE-1:0]                      m_mul_b_tdata,
    output logic                                 m_mul_tvalid,
    input  logic                                 m_mul_tready,
    input  logic [2:0][SIZE-1:0]                 s_mul_result_tdata,
    input  logic                                 s_mul_result_tvalid,
    output logic                                 s_mul_result_tready,
    // status
    output logic [$clog2(MAX_OUT):0]             outstanding,
    output logic                                 order_err
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int PTR_W = $clog2(MAX_OUT);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    idx_t       last_q;
    idx_t       grant_idx;
    logic [NREQ-1:0] grant;
    logic       grant_found;
    int         cand;
    logic       can_issue;
    logic       req_fire;

    idx_t       id_mem [MAX_OUT];
    ptr_t       wr_ptr_q;
    ptr_t       rd_ptr_q;
    cnt_t       cnt_q;
    logic       fifo_empty;
    idx_t       head;
    logic       rsp_valid;
    logic       rsp_fire;
    logic       orphan;

    // Round-robin search starting just past the last granted requester.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        cand        = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_q) + k) % NREQ;
            if (!grant_found && s_req_tvalid[idx_t'(cand)]) begin
                grant_found            = 1'b1;
                grant[idx_t'(cand)]    = 1'b1;
                grant_idx              = idx_t'(cand);
            end
        end
    end

    // aresetn gates the combinational readies so they are low for the whole reset, not just after an edge.
    assign can_issue    = aresetn && (cnt_q < cnt_t'(MAX_OUT)) && (!m_mul_tvalid || m_mul_tready);
    assign s_req_tready = can_issue ? grant : '0;
    assign req_fire     = |s_req_tready;

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_mul_tvalid  <= 1'b0;
            m_mul_a_tdata <= '0;
            m_mul_b_tdata <= '0;
            last_q        <= idx_t'(NREQ - 1);
        end else begin
            if (req_fire) begin
                m_mul_tvalid  <= 1'b1;
                m_mul_a_tdata <= s_req_a_tdata[grant_idx];
                m_mul_b_tdata <= s_req_b_tdata[grant_idx];
                last_q        <= grant_idx;
            end else if (m_mul_tready) begin
                m_mul_tvalid  <= 1'b0;
            end
        end
    end

    // NOTE: the ID storage has no reset; occupancy is tracked by cnt_q, so stale entries are never read.
    always_ff @(posedge aclk) begin
        if (req_fire) begin
            id_mem[wr_ptr_q] <= grant_idx;
        end
    end

    assign fifo_empty = (cnt_q == '0);
    assign head       = id_mem[rd_ptr_q];
    assign rsp_valid  = s_mul_result_tvalid && !fifo_empty;
    assign m_rsp_tdata = s_mul_result_tdata;

    // Results with no owner are swallowed so the multiplier never wedges.
    always_comb begin
        m_rsp_tvalid        = '0;
        s_mul_result_tready = 1'b0;
        if (aresetn) begin
            if (fifo_empty) begin
                s_mul_result_tready = 1'b1;
            end else begin
                s_mul_result_tready = m_rsp_tready[head];
                m_rsp_tvalid[head]  = s_mul_result_tvalid;
            end
        end
    end

    assign rsp_fire = rsp_valid && s_mul_result_tready;
    assign orphan   = s_mul_result_tvalid && fifo_empty;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            order_err <= 1'b0;
        end else begin
            if (req_fire) begin
                wr_ptr_q <= wr_ptr_q + ptr_t'(1);
            end
            if (rsp_fire) begin
                rd_ptr_q <= rd_ptr_q + ptr_t'(1);
            end
            case ({req_fire, rsp_fire})
                2'b10:   cnt_q <= cnt_q + cnt_t'(1);
                2'b01:   cnt_q <= cnt_q - cnt_t'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (orphan) begin
                order_err <= 1'b1;
            end
        end
    end

    assign outstanding = cnt_q;

endmodule

// File: tb/tb_vec_mul_sched.sv
// Directed bench for vec_mul_sched with an elastic 9-cycle float multiplier model.
module tb_vec_mul_sched;

    localparam int SIZE    = 32;
    localparam int NREQ    = 2;
    localparam int MAX_OUT = 16;
    localparam int LAT     = 9;

    localparam logic [31:0] F1 = 32'h3F80_0000;
    localparam logic [31:0] F2 = 32'h4000_0000;
    localparam logic [31:0] F3 = 32'h4040_0000;
    localparam logic [31:0] F4 = 32'h4080_0000;
    localparam logic [31:0] F6 = 32'h40C0_0000;
    localparam logic [31:0] F9 = 32'h4110_0000;

    logic                           aclk;
    logic                           aresetn;
    logic [NREQ-1:0][2:0][SIZE-1:0] s_req_a_tdata;
    logic [NREQ-1:0][SIZE-1:0]      s_req_b_tdata;
    logic [NREQ-1:0]                s_req_tvalid;
    logic [NREQ-1:0]                s_req_tready;
    logic [2:0][SIZE-1:0]           m_rsp_tdata;
    logic [NREQ-1:0]                m_rsp_tvalid;
    logic [NREQ-1:0]                m_rsp_tready;
    logic [2:0][SIZE-1:0]           m_mul_a_tdata;
    logic [SIZE-1:0]                m_mul_b_tdata;
    logic                           m_mul_tvalid;
    logic                           m_mul_tready;
    logic [2:0][SIZE-1:0]           s_mul_result_tdata;
    logic                           s_mul_result_tvalid;
    logic                           s_mul_result_tready;
    logic [$clog2(MAX_OUT):0]       outstanding;
    logic                           order_err;

    vec_mul_sched #(.SIZE(SIZE), .NREQ(NREQ), .MAX_OUT(MAX_OUT)) dut (
        .aclk                (aclk),
        .aresetn             (aresetn),
        .s_req_a_tdata       (s_req_a_tdata),
        .s_req_b_tdata       (s_req_b_tdata),
        .s_req_tvalid        (s_req_tvalid),
        .s_req_tready        (s_req_tready),
        .m_rsp_tdata         (m_rsp_tdata),
        .m_rsp_tvalid        (m_rsp_tvalid),
        .m_rsp_tready        (m_rsp_tready),
        .m_mul_a_tdata       (m_mul_a_tdata),
        .m_mul_b_tdata       (m_mul_b_tdata),
        .m_mul_tvalid        (m_mul_tvalid),
        .m_mul_tready        (m_mul_tready),
        .s_mul_result_tdata  (s_mul_result_tdata),
        .s_mul_result_tvalid (s_mul_result_tvalid),
        .s_mul_result_tready (s_mul_result_tready),
        .outstanding         (outstanding),
        .order_err           (order_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Truncating single-precision multiply, exact for the small operands used here.
    function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
        logic        s;
        logic [47:0] p;
        int          e;
        logic [22:0] m;
        s = x[31] ^ y[31];
        if (x[30:0] == '0 || y[30:0] == '0) return {s, 31'b0};
        p = {1'b1, x[22:0]} * {1'b1, y[22:0]};
        e = int'(x[30:23]) + int'(y[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        return {s, e[7:0], m};
    endfunction

    function automatic logic [2:0][31:0] vmul(input logic [2:0][31:0] a, input logic [31:0] b);
        logic [2:0][31:0] r;
        for (int k = 0; k < 3; k++) r[k] = fp_mul(a[k], b);
        return r;
    endfunction

    typedef struct {
        logic [2:0][31:0] data;
        longint           due;
    } mres_t;

    mres_t            mq[$];
    longint           cyc;
    logic             inject;
    logic [2:0][31:0] inject_data;

    // Multiplier model: fixed latency into an elastic output queue, flushed by the shared reset.
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mq.delete();
            cyc                 <= 0;
            s_mul_result_tvalid <= 1'b0;
            s_mul_result_tdata  <= '0;
        end else begin
            if (s_mul_result_tvalid && s_mul_result_tready) mq.delete(0);
            if (m_mul_tvalid && m_mul_tready) mq.push_back('{vmul(m_mul_a_tdata, m_mul_b_tdata), cyc + LAT});
            if (inject) mq.push_back('{inject_data, cyc});
            cyc <= cyc + 1;
            if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
                s_mul_result_tvalid <= 1'b1;
                s_mul_result_tdata  <= mq[0].data;
            end else begin
                s_mul_result_tvalid <= 1'b0;
            end
        end
    end

    int               grant_log[$];
    int               rsp_idx[$];
    logic [2:0][31:0] rsp_dat[$];

    always @(posedge aclk) begin
        if (aresetn) begin
            for (int i = 0; i < NREQ; i++) begin
                if (s_req_tvalid[i] && s_req_tready[i]) grant_log.push_back(i);
                if (m_rsp_tvalid[i] && m_rsp_tready[i]) begin
                    rsp_idx.push_back(i);
                    rsp_dat.push_back(m_rsp_tdata);
                end
            end
        end
    end

    function automatic int count_grants(input int idx);
        int c = 0;
        foreach (grant_log[k]) if (grant_log[k] == idx) c++;
        return c;
    endfunction

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_logs();
        grant_log.delete();
        rsp_idx.delete();
        rsp_dat.delete();
    endtask

    task automatic do_reset();
        aresetn      = 1'b0;
        s_req_tvalid = '0;
        m_rsp_tready = '1;
        m_mul_tready = 1'b1;
        inject       = 1'b0;
        step();
        step();
        aresetn = 1'b1;
        step();
        clear_logs();
    endtask

    task automatic wait_rsp(input int n, input string tag);
        for (int i = 0; i < 200 && rsp_idx.size() < n; i++) step();
        check(tag, 160'(rsp_idx.size()), 160'(n));
    endtask

    task automatic wait_result_valid(input string tag);
        for (int i = 0; i < 60 && !s_mul_result_tvalid; i++) step();
        check(tag, 160'(s_mul_result_tvalid), 160'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        aresetn       = 1'b0;
        s_req_a_tdata = '0;
        s_req_b_tdata = '0;
        s_req_tvalid  = 2'b11;
        m_rsp_tready  = 2'b11;
        m_mul_tready  = 1'b1;
        inject        = 1'b0;
        inject_data   = '0;
        #12;
        check("reset_state",
              {s_req_tready, m_mul_tvalid, m_mul_a_tdata, m_mul_b_tdata, m_rsp_tvalid, s_mul_result_tready, outstanding, order_err},
              160'(0));
        do_reset();

        // Single issue
        s_req_a_tdata[0] = {F3, F2, F1};
        s_req_b_tdata[0] = F2;
        s_req_tvalid     = 2'b01;
        #1;
        check("t1_tready", 160'(s_req_tready), 160'(2'b01));
        step();
        s_req_tvalid = '0;
        check("t1_issue", {m_mul_tvalid, m_mul_a_tdata, m_mul_b_tdata}, {1'b1, F3, F2, F1, F2});
        check("t1_out1", 160'(outstanding), 160'(1));
        step();
        check("t1_issue_clr", 160'(m_mul_tvalid), 160'(0));
        for (int i = 0; i < 40 && m_rsp_tvalid == '0; i++) step();
        check("t1_rsp", {m_rsp_tvalid, m_rsp_tdata}, {2'b01, F6, F4, F2});
        step();
        check("t1_out0", 160'(outstanding), 160'(0));

        // Fairness
        do_reset();
        s_req_a_tdata[0] = {F1, F1, F1};
        s_req_b_tdata[0] = F2;
        s_req_a_tdata[1] = {F1, F1, F1};
        s_req_b_tdata[1] = F3;
        s_req_tvalid     = 2'b11;
        repeat (4) step();
        s_req_tvalid = '0;
        check("t2_ngrants", 160'(grant_log.size()), 160'(4));
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check($sformatf("t2_grant%0d", i), 160'(grant_log[i]), 160'(i % 2));
        wait_rsp(4, "t2_nrsp");
        for (int i = 0; i < 4 && i < rsp_idx.size(); i++)
            check($sformatf("t2_rsp%0d", i), {rsp_idx[i][0], rsp_dat[i]},
                  (i % 2 == 1) ? {1'b1, F3, F3, F3} : {1'b0, F2, F2, F2});

        // Credits
        do_reset();
        m_rsp_tready     = '0;
        s_req_a_tdata[0] = {F1, F1, F1};
        s_req_b_tdata[0] = F2;
        s_req_tvalid     = 2'b01;
        repeat (30) step();
        check("t3_acc16", 160'(count_grants(0)), 160'(16));
        check("t3_full", {s_req_tready, outstanding}, {2'b00, 5'd16});
        check("t3_head_stall", {s_mul_result_tvalid, m_rsp_tvalid, s_mul_result_tready}, {1'b1, 2'b01, 1'b0});
        m_rsp_tready = 2'b01;
        step();
        m_rsp_tready = '0;
        check("t3_after_pop", {outstanding, s_req_tready}, {5'd15, 2'b01});
        repeat (5) step();
        check("t3_acc17", {16'(count_grants(0)), outstanding, 16'(rsp_idx.size())}, {16'd17, 5'd16, 16'd1});

        // Multiplier stall
        do_reset();
        m_mul_tready     = 1'b0;
        s_req_a_tdata[0] = {F3, F2, F1};
        s_req_b_tdata[0] = F2;
        s_req_tvalid     = 2'b01;
        step();
        s_req_a_tdata[0] = {F1, F2, F3};
        s_req_b_tdata[0] = F3;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4_hold%0d", i), {m_mul_tvalid, s_req_tready, m_mul_a_tdata, m_mul_b_tdata},
                  {1'b1, 2'b00, F3, F2, F1, F2});
            step();
        end
        check("t4_acc_stalled", 160'(count_grants(0)), 160'(1));
        m_mul_tready = 1'b1;
        #1;
        check("t4_resume_tready", 160'(s_req_tready), 160'(2'b01));
        step();
        s_req_tvalid = '0;
        check("t4_reload", {16'(count_grants(0)), m_mul_tvalid, m_mul_a_tdata, m_mul_b_tdata},
              {16'd2, 1'b1, F1, F2, F3, F3});
        wait_rsp(2, "t4_nrsp");
        if (rsp_dat.size() >= 2) begin
            check("t4_rsp0", rsp_dat[0], {F6, F4, F2});
            check("t4_rsp1", rsp_dat[1], {F3, F6, F9});
        end

        // Response back-pressure
        do_reset();
        m_rsp_tready     = 2'b01;
        s_req_a_tdata[0] = {F1, F1, F1};
        s_req_b_tdata[0] = F2;
        s_req_a_tdata[1] = {F1, F1, F1};
        s_req_b_tdata[1] = F3;
        s_req_tvalid     = 2'b10;
        step();
        s_req_tvalid = 2'b01;
        repeat (3) step();
        s_req_tvalid = '0;
        wait_result_valid("t5_result_arrives");
        check("t5_head1_stall", {m_rsp_tvalid, s_mul_result_tready}, {2'b10, 1'b0});
        repeat (3) step();
        check("t5_held", {outstanding, 16'(rsp_idx.size())}, {5'd4, 16'd0});
        s_req_tvalid = 2'b01;
        #1;
        check("t5_issue_ok", 160'(s_req_tready), 160'(2'b01));
        step();
        step();
        s_req_tvalid = '0;
        check("t5_more_acc", {16'(count_grants(0)), outstanding}, {16'd5, 5'd6});
        m_rsp_tready = 2'b11;
        wait_rsp(6, "t5_nrsp");
        for (int i = 0; i < 6 && i < rsp_idx.size(); i++)
            check($sformatf("t5_rsp%0d", i), {rsp_idx[i][0], rsp_dat[i]},
                  (i == 0) ? {1'b1, F3, F3, F3} : {1'b0, F2, F2, F2});

        // Orphan result and mid-burst reset
        step();
        check("t6_empty", {outstanding, order_err}, {5'd0, 1'b0});
        inject_data = {F1, F2, F3};
        inject      = 1'b1;
        step();
        inject = 1'b0;
        check("t6_orphan_vis", {s_mul_result_tvalid, m_rsp_tvalid, s_mul_result_tready, order_err},
              {1'b1, 2'b00, 1'b1, 1'b0});
        step();
        check("t6_orphan_drop", {order_err, s_mul_result_tvalid, outstanding}, {1'b1, 1'b0, 5'd0});
        s_req_tvalid = 2'b11;
        step();
        step();
        check("t6_burst", 160'(outstanding), 160'(2));
        #2;
        aresetn = 1'b0;
        #1;
        check("t6_reset_vals",
              {s_req_tready, m_mul_tvalid, m_mul_a_tdata, m_mul_b_tdata, m_rsp_tvalid, s_mul_result_tready, outstanding, order_err},
              160'(0));
        step();
        aresetn = 1'b1;
        clear_logs();
        #1;
        check("t6_prio_req0", 160'(s_req_tready), 160'(2'b01));
        step();
        s_req_tvalid = '0;
        check("t6_first_grant", {m_mul_tvalid, m_mul_b_tdata, outstanding}, {1'b1, F2, 5'd1});
        wait_rsp(1, "t6_nrsp");
        repeat (15) step();
        check("t6_no_stale", {16'(rsp_idx.size()), outstanding, order_err}, {16'd1, 5'd0, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
